// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - dual-issue in-order scheduler with E/M1/M2 producer scoreboard
module issue_sched #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in_valid,
    input  logic [2*REGW-1:0]   in_ra1,
    input  logic [2*REGW-1:0]   in_ra2,
    input  logic [2*REGW-1:0]   in_rdst,
    input  logic [1:0]          in_regwrite,
    input  logic [1:0]          in_delayed,
    input  logic [1:0]          in_memop,
    input  logic                stall,
    input  logic                flush,
    output logic [1:0]          issue,
    output logic                sb_busy,
    output logic [CNTW-1:0]     hazard_cycles
);

    // Stage index 0=E, 1=M1, 2=M2; slot 1 of a stage is younger than slot 0.
    logic [1:0]      sb_valid [3];
    logic [1:0]      sb_rw    [3];
    logic [1:0]      sb_dly   [3];
    logic [REGW-1:0] sb_rdst  [3][2];

    logic [REGW-1:0] ra1_0, ra2_0, ra1_1, ra2_1, rdst_0, rdst_1;
    logic            intra;

    // Youngest matching producer decides; only delayed results still in E or M1 stall.
    function automatic logic src_blocked(input logic [REGW-1:0] r);
        logic found;
        logic blk;
        found = 1'b0;
        blk   = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int j = 1; j >= 0; j--) begin
                if (!found && (r != '0) && sb_valid[s][j] && sb_rw[s][j] && (sb_rdst[s][j] == r)) begin
                    found = 1'b1;
                    blk   = sb_dly[s][j] && (s < 2);
                end
            end
        end
        return blk;
    endfunction

    always_comb begin
        ra1_0  = in_ra1[REGW-1:0];
        ra1_1  = in_ra1[2*REGW-1:REGW];
        ra2_0  = in_ra2[REGW-1:0];
        ra2_1  = in_ra2[2*REGW-1:REGW];
        rdst_0 = in_rdst[REGW-1:0];
        rdst_1 = in_rdst[2*REGW-1:REGW];
        intra  = in_regwrite[0] && (rdst_0 != '0) && ((rdst_0 == ra1_1) || (rdst_0 == ra2_1));
        issue[0] = in_valid[0] && !stall && !flush && !src_blocked(ra1_0) && !src_blocked(ra2_0);
        issue[1] = issue[0] && in_valid[1] && !src_blocked(ra1_1) && !src_blocked(ra2_1)
                   && !intra && !(in_memop[0] && in_memop[1]);
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int s = 0; s < 2; s++)
            sb_busy = sb_busy || |(sb_valid[s] & sb_dly[s]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hazard_cycles <= '0;
            for (int s = 0; s < 3; s++) begin
                sb_valid[s]   <= '0;
                sb_rw[s]      <= '0;
                sb_dly[s]     <= '0;
                sb_rdst[s][0] <= '0;
                sb_rdst[s][1] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < 3; s++)
                sb_valid[s] <= '0;
        end else if (!stall) begin
            if (in_valid[0] && !issue[0])
                hazard_cycles <= hazard_cycles + CNTW'(1);
            for (int s = 2; s > 0; s--) begin
                sb_valid[s]   <= sb_valid[s-1];
                sb_rw[s]      <= sb_rw[s-1];
                sb_dly[s]     <= sb_dly[s-1];
                sb_rdst[s][0] <= sb_rdst[s-1][0];
                sb_rdst[s][1] <= sb_rdst[s-1][1];
            end
            sb_valid[0]   <= issue;
            sb_rw[0]      <= in_regwrite;
            sb_dly[0]     <= in_delayed;
            sb_rdst[0][0] <= rdst_0;
            sb_rdst[0][1] <= rdst_1;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// tb/tb_issue_sched.sv - randomized and directed self-checking bench for issue_sched
module tb_issue_sched;

    logic        clk;
    logic        reset;
    logic [1:0]  in_valid;
    logic [9:0]  in_ra1, in_ra2, in_rdst;
    logic [1:0]  in_regwrite, in_delayed, in_memop;
    logic        stall, flush;
    logic [1:0]  issue;
    logic        sb_busy;
    logic [31:0] hazard_cycles;

    issue_sched #(.REGW(5), .CNTW(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_rdst(in_rdst),
        .in_regwrite(in_regwrite), .in_delayed(in_delayed), .in_memop(in_memop),
        .stall(stall), .flush(flush), .issue(issue), .sb_busy(sb_busy),
        .hazard_cycles(hazard_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each granted instruction is remembered with how many advances ago it issued.
    typedef struct {
        int       age;
        int       slot;
        bit [4:0] rd;
        bit       rw;
        bit       dly;
    } rec_t;

    rec_t        hist[$];
    logic [31:0] m_haz = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit m_blocked(input bit [4:0] r);
        int best_age;
        int best_slot;
        bit d;
        best_age  = 99;
        best_slot = -1;
        d         = 1'b0;
        if (r == 5'd0) return 1'b0;
        foreach (hist[k]) begin
            if (hist[k].rw && hist[k].rd == r &&
                (hist[k].age < best_age || (hist[k].age == best_age && hist[k].slot > best_slot))) begin
                best_age  = hist[k].age;
                best_slot = hist[k].slot;
                d         = hist[k].dly;
            end
        end
        return d && (best_age <= 1);
    endfunction

    function automatic logic [1:0] m_issue();
        logic [1:0] g;
        bit [4:0] a10, a20, a11, a21, d0;
        bit intra;
        a10 = in_ra1[4:0]; a11 = in_ra1[9:5];
        a20 = in_ra2[4:0]; a21 = in_ra2[9:5];
        d0  = in_rdst[4:0];
        intra = in_regwrite[0] && d0 != 5'd0 && (d0 == a11 || d0 == a21);
        g[0] = in_valid[0] && !stall && !flush && !m_blocked(a10) && !m_blocked(a20);
        g[1] = g[0] && in_valid[1] && !m_blocked(a11) && !m_blocked(a21) && !intra
               && !(in_memop[0] && in_memop[1]);
        return g;
    endfunction

    function automatic logic m_busy();
        foreach (hist[k])
            if (hist[k].dly && hist[k].age <= 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_advance(input logic [1:0] g);
        rec_t nq[$];
        rec_t r;
        foreach (hist[k]) begin
            if (hist[k].age < 2) begin
                r = hist[k];
                r.age = r.age + 1;
                nq.push_back(r);
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (g[j]) begin
                r.age  = 0;
                r.slot = j;
                r.rd   = in_rdst[j*5 +: 5];
                r.rw   = in_regwrite[j];
                r.dly  = in_delayed[j];
                nq.push_back(r);
            end
        end
        hist = nq;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_haz = 32'd0;
        end else if (flush) begin
            hist.delete();
        end else if (!stall) begin
            logic [1:0] g;
            g = m_issue();
            if (in_valid[0] && !g[0]) m_haz = m_haz + 32'd1;
            m_advance(g);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("issue", {30'd0, issue}, {30'd0, m_issue()});
            chk("sb_busy", {31'd0, sb_busy}, {31'd0, m_busy()});
            chk("hazard_cycles", hazard_cycles, m_haz);
        end
    end

    task automatic clear_in();
        in_valid = 2'b00; in_ra1 = '0; in_ra2 = '0; in_rdst = '0;
        in_regwrite = 2'b00; in_delayed = 2'b00; in_memop = 2'b00;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic slot(input int i, input int ra1, input int ra2, input int rd,
                        input bit rw, input bit dly, input bit mem);
        in_valid[i]      = 1'b1;
        in_ra1[i*5 +: 5] = ra1[4:0];
        in_ra2[i*5 +: 5] = ra2[4:0];
        in_rdst[i*5 +: 5] = rd[4:0];
        in_regwrite[i]   = rw;
        in_delayed[i]    = dly;
        in_memop[i]      = mem;
    endtask

    // Check literal expectations at the negedge, then move past the next posedge.
    task automatic step(input logic [1:0] ei, input int eb = -1, input int eh = -1);
        @(negedge clk);
        chk("dir_issue", {30'd0, issue}, {30'd0, ei});
        if (eb >= 0) chk("dir_sb_busy", {31'd0, sb_busy}, eb[31:0]);
        if (eh >= 0) chk("dir_hazard", hazard_cycles, eh[31:0]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        step(2'b00, 0, 0);
        reset = 1'b0;

        // independent pair
        clear_in(); slot(0, 3, 4, 5, 1, 0, 0); slot(1, 6, 0, 7, 1, 0, 0);
        step(2'b11, 0, 0);
        // load then dependent consumer
        clear_in(); slot(0, 0, 0, 8, 1, 1, 1);
        step(2'b01, 0, 0);
        clear_in(); slot(0, 8, 0, 11, 0, 0, 0);
        step(2'b00, 1, 0);
        step(2'b00, 1, 1);
        step(2'b01, 0, 2);
        // intra-pair dependency
        clear_in(); slot(0, 0, 0, 9, 1, 0, 0); slot(1, 0, 9, 15, 1, 0, 0);
        step(2'b01);
        clear_in(); slot(0, 0, 9, 15, 1, 0, 0);
        step(2'b01);
        clear_in(); slot(0, 0, 0, 0, 1, 0, 0); slot(1, 0, 0, 16, 1, 0, 0);
        step(2'b11);
        // younger non-delayed producer masks older delayed one
        clear_in(); slot(0, 0, 0, 10, 1, 1, 0);
        step(2'b01, 0);
        clear_in(); slot(0, 0, 0, 10, 1, 0, 0);
        step(2'b01, 1);
        clear_in(); slot(0, 10, 0, 17, 1, 0, 0);
        step(2'b01, 1, 2);
        // paired memops, then stall during a pending hazard
        clear_in(); slot(0, 1, 0, 0, 0, 0, 1); slot(1, 2, 0, 0, 0, 0, 1);
        step(2'b01);
        clear_in(); slot(0, 0, 0, 12, 1, 1, 1);
        step(2'b01);
        clear_in(); slot(0, 12, 0, 18, 1, 0, 0); stall = 1'b1;
        repeat (3) step(2'b00, 1, 2);
        stall = 1'b0;
        step(2'b00, 1, 2);
        step(2'b00, 1, 3);
        step(2'b01, 0, 4);
        // flush removes the pending load
        clear_in(); slot(0, 0, 0, 8, 1, 1, 1);
        step(2'b01, 0, 4);
        clear_in(); slot(0, 8, 0, 19, 1, 0, 0); flush = 1'b1;
        step(2'b00, 1, 4);
        flush = 1'b0;
        step(2'b01, 0, 4);
        // asynchronous reset while busy
        clear_in(); slot(0, 0, 0, 13, 1, 1, 1);
        step(2'b01, 0, 4);
        clear_in(); slot(0, 13, 0, 20, 1, 0, 0);
        #2;
        chk("busy_before_reset", {31'd0, sb_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("busy_async_reset", {31'd0, sb_busy}, 32'd0);
        chk("haz_async_reset", hazard_cycles, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized traffic over a small register set to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) != 0)
                    slot(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
                else
                    in_rdst[i*5 +: 5] = 5'($urandom_range(0, 31));
            end
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        clear_in();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
